// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, frame geometry and scan-code prefixes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_DATA_BITS  = 8;
    localparam logic       PS2_IDLE_LEVEL = 1'b1;

    // Prefix bytes the keycode stage looks for in the raw byte stream.
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a persistence glitch filter for one PS/2 line.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int GLITCH_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_line
);

    localparam int CW = $clog2(GLITCH_CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_line;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= {2{PS2_IDLE_LEVEL}};
        else          r_sync <= {r_sync[0], i_raw};
    end

    // Flip the output only after GLITCH_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line <= PS2_IDLE_LEVEL;
            r_cnt  <= '0;
        end else if (r_sync[1] == r_line) begin
            r_cnt  <= '0;
        end else if (r_cnt == CW'(GLITCH_CYCLES - 1)) begin
            r_line <= r_sync[1];
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: conditions the lines, deserialises 11-bit
// frames on filtered clock falls and strobes out one checked byte per frame.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int GLITCH_CYCLES = 8,
    parameter int TIMEOUT_US    = 2000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       rx_enable,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TIMEOUT_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW             = $clog2(PS2_DATA_BITS);

    logic                     w_clk_f;
    logic                     w_dat_f;
    logic                     w_fall;
    logic                     w_timeout;
    logic                     w_good;
    logic                     w_perr;
    logic                     w_ferr;
    ps2_state_t               w_state_nx;

    ps2_state_t               r_state;
    logic                     r_clk_d;
    logic [BW-1:0]            r_bit_cnt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic                     r_par;
    logic [TW-1:0]            r_to_cnt;
    logic [7:0]               r_data;
    logic                     r_data_en;
    logic                     r_perr;
    logic                     r_ferr;

    ps2_line_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_clk_filt (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_raw   (PS2_CLK),
        .o_line  (w_clk_f)
    );

    ps2_line_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_dat_filt (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_raw   (PS2_DAT),
        .o_line  (w_dat_f)
    );

    assign w_fall    = r_clk_d & ~w_clk_f;
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES));

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) r_clk_d <= PS2_IDLE_LEVEL;
        else          r_clk_d <= w_clk_f;
    end

    // Next state and frame verdict; a fall outranks a coincident timeout.
    always_comb begin
        w_state_nx = r_state;
        w_good     = 1'b0;
        w_perr     = 1'b0;
        w_ferr     = 1'b0;
        if (!rx_enable) begin
            w_state_nx = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_dat_f) w_state_nx = ST_DATA;
                ST_DATA:   if (r_bit_cnt == BW'(PS2_DATA_BITS - 1)) w_state_nx = ST_PARITY;
                ST_PARITY: w_state_nx = ST_STOP;
                ST_STOP: begin
                    w_state_nx = ST_IDLE;
                    if (!w_dat_f)                          w_ferr = 1'b1;
                    else if (!ps2_parity_ok(r_shift, r_par)) w_perr = 1'b1;
                    else                                   w_good = 1'b1;
                end
                default:   w_state_nx = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nx = ST_IDLE;
            w_ferr     = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nx;
    end

    // Bit capture: start clears the partial byte, data bits land LSB first.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
        end else if (rx_enable && w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                end
                ST_DATA: begin
                    r_shift[r_bit_cnt] <= w_dat_f;
                    r_bit_cnt          <= r_bit_cnt + 1'b1;
                end
                ST_PARITY: r_par <= w_dat_f;
                default: ;
            endcase
        end
    end

    // Inter-edge watchdog: idles at zero, restarts on every fall, parks at terminal count.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)                         r_to_cnt <= '0;
        else if (r_state == ST_IDLE || w_fall) r_to_cnt <= '0;
        else if (!w_timeout)                  r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Output byte and single-cycle, mutually exclusive strobes.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= 8'h00;
            r_data_en <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_data_en <= w_good;
            r_perr    <= w_perr;
            r_ferr    <= w_ferr;
            if (w_good) r_data <= r_shift;
        end
    end

    assign received_data    = r_data;
    assign received_data_en = r_data_en;
    assign parity_err       = r_perr;
    assign frame_err        = r_ferr;
    assign busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of whole frames plus hand sequences for
// glitch, timeout, reset and rx_enable corner cases.
module tb_ps2_rx;
    import ps2_pkg::*;

    // 1 MHz system clock makes 1 cycle = 1 us; timeout scaled to 300 us.
    localparam int CLK_HZ  = 1000000;
    localparam int TO_US   = 300;
    localparam int HALF    = 30;   // half of a 60 us PS/2 bit period

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic       rx_enable = 1'b1;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    ps2_rx #(.CLK_HZ(CLK_HZ), .GLITCH_CYCLES(8), .TIMEOUT_US(TO_US)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset_n          (reset_n),
        .PS2_CLK          (PS2_CLK),
        .PS2_DAT          (PS2_DAT),
        .rx_enable        (rx_enable),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .parity_err       (parity_err),
        .frame_err        (frame_err),
        .busy             (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int n_en = 0, n_perr = 0, n_ferr = 0, n_excl = 0;

    // Strobe counters sampled mid-cycle.
    always @(negedge CLOCK_50) begin
        if (reset_n) begin
            if (received_data_en) n_en++;
            if (parity_err)       n_perr++;
            if (frame_err)        n_ferr++;
            if (int'(received_data_en) + int'(parity_err) + int'(frame_err) > 1) n_excl++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Device-style bit: data changes while clock is high, then clock pulses low.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = frame[i];
            wait_clk(HALF);
            PS2_CLK = 1'b0;
            wait_clk(HALF);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bits({stop, par, d, 1'b0}, PS2_FRAME_BITS);
        PS2_DAT = 1'b1;
        wait_clk(HALF);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         en;
        int         perr;
        int         ferr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   e0, p0, f0, hi;

        vecs[0] = '{8'h1C,    1'b1, 1'b1, 0, 1, 0, 8'h00};  // parity error after reset
        vecs[1] = '{8'h1C,    1'b0, 1'b1, 1, 0, 0, 8'h1C};
        vecs[2] = '{PS2_BREAK, 1'b1, 1'b1, 1, 0, 0, 8'hF0};  // back-to-back F0, 1C
        vecs[3] = '{8'h1C,    1'b0, 1'b1, 1, 0, 0, 8'h1C};
        vecs[4] = '{8'h5A,    1'b1, 1'b0, 0, 0, 1, 8'h1C};  // bad stop bit

        wait_clk(3);
        chk("rst_data",  int'(received_data), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_strobe", int'({received_data_en, parity_err, frame_err}), 0);
        reset_n = 1'b1;
        wait_clk(20);

        for (int v = 0; v < 5; v++) begin
            e0 = n_en; p0 = n_perr; f0 = n_ferr;
            send_frame(vecs[v].d, vecs[v].par, vecs[v].stop);
            chk($sformatf("v%0d_en", v),   n_en - e0,   vecs[v].en);
            chk($sformatf("v%0d_perr", v), n_perr - p0, vecs[v].perr);
            chk($sformatf("v%0d_ferr", v), n_ferr - f0, vecs[v].ferr);
            chk($sformatf("v%0d_data", v), int'(received_data), int'(vecs[v].data));
            chk($sformatf("v%0d_busy", v), int'(busy), 0);
        end

        // Short low glitch on the idle clock line must not disturb anything.
        e0 = n_en; p0 = n_perr; f0 = n_ferr; hi = 0;
        PS2_CLK = 1'b0;
        wait_clk(3);
        PS2_CLK = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (busy) hi++;
        end
        wait_clk(1);
        chk("glitch_busy", hi, 0);
        chk("glitch_strobes", (n_en - e0) + (n_perr - p0) + (n_ferr - f0), 0);

        // Partial frame then silence: watchdog aborts it.
        e0 = n_en; f0 = n_ferr;
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5);
        PS2_DAT = 1'b1;
        chk("to_busy_mid", int'(busy), 1);
        wait_clk(TO_US + 100);
        chk("to_ferr", n_ferr - f0, 1);
        chk("to_busy", int'(busy), 0);
        chk("to_no_en", n_en - e0, 0);
        e0 = n_en;
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("to_next_en", n_en - e0, 1);
        chk("to_next_data", int'(received_data), 'h5A);

        // Reset asserted during data bit 5.
        send_bits({1'b1, 1'b0, PS2_EXT, 1'b0}, 6);
        PS2_DAT = PS2_EXT[5];
        wait_clk(10);
        reset_n = 1'b0;
        #1;
        chk("mrst_data", int'(received_data), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_strobe", int'({received_data_en, parity_err, frame_err}), 0);
        PS2_DAT = 1'b1;
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(20);
        e0 = n_en;
        send_frame(PS2_EXT, 1'b0, 1'b1);
        chk("mrst_next_en", n_en - e0, 1);
        chk("mrst_next_data", int'(received_data), 'hE0);

        // rx_enable dropped mid-frame: silent abort, no watchdog strobe later.
        e0 = n_en; p0 = n_perr; f0 = n_ferr;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
        chk("dis_busy_mid", int'(busy), 1);
        rx_enable = 1'b0;
        wait_clk(2);
        chk("dis_busy", int'(busy), 0);
        PS2_DAT = 1'b1;
        wait_clk(TO_US + 100);
        chk("dis_strobes", (n_en - e0) + (n_perr - p0) + (n_ferr - f0), 0);
        chk("dis_data", int'(received_data), 'hE0);
        rx_enable = 1'b1;
        wait_clk(20);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("dis_next_en", n_en - e0, 1);
        chk("dis_next_data", int'(received_data), 'h1C);

        chk("strobe_excl", n_excl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host receiver: synchronises and de-glitches the PS2_CLK/PS2_DAT lines, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), and emits one validated scan-code byte per frame.
- Sits directly upstream of the keyboard keycode/handler stage, which consumes received_data/received_data_en as raw scan-code bytes (including E0/F0 prefixes).
- Receive-only: never drives the bus.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used to derive the timeout cycle count.
- GLITCH_CYCLES, 8, consecutive equal synchronised samples required before a filtered line changes; range 1..255.
- TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside a frame before the frame is aborted.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- PS2_CLK  in  1  raw PS/2 clock line, asynchronous.
- PS2_DAT  in  1  raw PS/2 data line, asynchronous.
- rx_enable  in  1  1 = receive; 0 = hold in IDLE and abort any frame in progress.
- received_data  out  8  last good byte; held until the next good byte.
- received_data_en  out  1  one-cycle strobe; received_data is valid in that cycle.
- parity_err  out  1  one-cycle strobe on a parity failure.
- frame_err  out  1  one-cycle strobe on a bad stop bit or a timeout.
- busy  out  1  high when not in IDLE.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (CLOCK_50, reset_n).
- Reset values: received_data = 0x00; all strobes = 0; busy = 0; state = IDLE; filtered lines = 1 (bus idle high).
- Line conditioning:
  - 2-flop synchroniser per line.
  - Glitch filter per line: the output flips only after GLITCH_CYCLES consecutive samples that differ from the current output.
  - Counter width is $clog2(GLITCH_CYCLES+1).
- Edge detect: fall = filtered clock was 1 last cycle and is 0 now. Detection latency from pin change is 2+GLITCH_CYCLES+1 cycles.
- FSM, advancing only on fall:
  - IDLE: if data=0, go to DATA with bit_cnt=0. If data=1 (false start), stay in IDLE with no error.
  - DATA: shift data into bit[bit_cnt], LSB first. After bit 7 (bit_cnt wraps 7 -> 0), go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP, stop=1 and XOR(data,parity)=1: update received_data and pulse received_data_en on the following cycle.
  - STOP, parity wrong: pulse parity_err only. received_data is unchanged.
  - STOP, stop=0: pulse frame_err. Stop-bit failure takes priority over parity failure; only one strobe is pulsed.
  - STOP always returns to IDLE.
- Timeout:
  - TIMEOUT_CYCLES = CLK_HZ/1000000*TIMEOUT_US.
  - A counter runs while not IDLE and clears on every fall.
  - When the counter reaches TIMEOUT_CYCLES: pulse frame_err, go to IDLE, discard partial bits.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- rx_enable=0: FSM forced to IDLE the next cycle; no strobes; filters keep running.
- Simultaneous fall and timeout terminal count in the same cycle: the fall wins and the counter clears.
- Strobe exclusivity: at most one of received_data_en / parity_err / frame_err is high in any cycle.
- Strobe rate: strobes never repeat without a new frame.
- Reset mid-frame: immediate return to reset values; the next frame is received normally.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - PS2_FRAME_BITS=11, PS2_DATA_BITS=8.
  - PS2_IDLE_LEVEL=1.
  - Scan-code prefix constants PS2_EXT=0xE0 and PS2_BREAK=0xF0, shared with the keycode stage.
- Sub-module ps2_line_filter: synchroniser plus glitch filter, parameterised by GLITCH_CYCLES, reset to 1. Instantiated once for the clock and once for the data line.

Test Plan:
- Frame 0x1C (parity 0, stop 1), 60 us bit period -> one received_data_en pulse with received_data=0x1C; no error strobes; busy low after the stop bit.
- Back-to-back frames F0 (parity 1), 1C (parity 0) -> two strobes in order: 0xF0, then 0x1C.
- Frame 0x1C with parity 1 -> parity_err pulse only; received_data keeps its prior value (0x00 after reset).
- 3-cycle low glitch on PS2_CLK while idle, and a stop bit of 0 on frame 0x5A -> the glitch produces no state change; the bad frame gives a frame_err pulse only.
- Send start plus 4 data bits, then hold the lines high for >2 ms -> frame_err pulse, busy=0. A following frame 0x5A (parity 1) -> received_data_en with 0x5A.
- Assert reset_n low during bit 5 of a frame, then release -> outputs return to reset values immediately. Next frame 0xE0 (parity 0) -> received correctly. Repeat with rx_enable dropped mid-frame -> abort with no strobe.
